// File: rtl/rand_server.sv
// Shared random-number service: free-running 12-bit LFSR, round-robin arbitration,
// and per-grant uniform draws in [0, limit) by mask-and-reject with a bounded retry count.
module rand_server #(
    parameter int NREQ      = 4,
    parameter int W         = 12,
    parameter int MAX_TRIES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      seed,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] limit,
    output logic [NREQ-1:0]   gnt,
    output logic              valid,
    output logic [W-1:0]      rnd
);
    localparam int PW = $clog2(NREQ);
    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t        state, state_next;
    logic [W-1:0]  r, r_next, t;
    logic [PW-1:0] ptr, idx, sel_idx;
    logic          found;
    logic [W-1:0]  sel_lim, lim_m1, mask, mask_new, cand;
    logic [W:0]    lim, lim_new;
    logic [TW-1:0] tries;
    logic          accept, last;

    // All-ones up to and including the highest set bit of x.
    function automatic logic [W-1:0] smear(input logic [W-1:0] x);
        logic [W-1:0] m;
        m = x;
        for (int i = W - 2; i >= 0; i--) m[i] = m[i+1] | x[i];
        return m;
    endfunction

    // 0 is escaped to fff and fff folds back to 0, so every 12-bit value is visited.
    always_comb begin
        t = {r[6] ^ r[4] ^ r[1] ^ r[0], r[W-1:1]};
        if (r == '0) r_next = '1;
        else         r_next = (t == '1) ? '0 : t;
    end

    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                found   = 1'b1;
                sel_idx = PW'((int'(ptr) + k) % NREQ);
            end
        end
        sel_lim  = limit[int'(sel_idx)*W +: W];
        lim_new  = (sel_lim == '0) ? ((W+1)'(1) << W) : {1'b0, sel_lim};
        lim_m1   = (sel_lim == '0) ? '1 : sel_lim - W'(1);
        mask_new = smear(lim_m1);
    end

    always_comb begin
        cand   = r & mask;
        accept = ({1'b0, cand} < lim);
        last   = (tries == TW'(MAX_TRIES - 1));
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = DRAW;
            DRAW:    if (accept || last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r     <= seed;
            state <= IDLE;
            ptr   <= PW'(NREQ - 1);
            idx   <= '0;
            lim   <= '0;
            mask  <= '0;
            tries <= '0;
            gnt   <= '0;
            valid <= 1'b0;
            rnd   <= '0;
        end else begin
            r     <= r_next;
            state <= state_next;
            gnt   <= '0;
            valid <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    idx   <= sel_idx;
                    lim   <= lim_new;
                    mask  <= mask_new;
                    tries <= '0;
                end
                DRAW: begin
                    // Outputs are registered so they are high for the whole DONE cycle.
                    if (accept || last) begin
                        rnd   <= accept ? cand : cand - lim[W-1:0];
                        valid <= 1'b1;
                        gnt   <= NREQ'(1) << idx;
                        ptr   <= idx;
                    end else begin
                        tries <= tries + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
